// File: rtl/text_terminal_writer.sv
// text_terminal_writer: turns a character stream into writes to a 64x32 text RAM,
// tracking the cursor and handling CR/LF/BS/FF, scroll-up and full-screen clear.
module text_terminal_writer #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter bit         LF_ON_WRAP = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [4:0]  cursor_row,
  output logic [5:0]  cursor_col,
  output logic        busy
);
  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCRD, SCWR, FILL} state_t;
  state_t      r_state, w_next;
  logic [10:0] r_addr;
  logic [4:0]  r_row;
  logic [5:0]  r_col;
  logic [7:0]  r_char;
  logic        r_wr;
  logic        w_xfer, w_print, w_wrap_scroll;
  assign w_xfer        = char_valid && r_state == IDLE;
  assign w_print       = char_data >= 8'h20 && char_data != 8'h7F;
  assign w_wrap_scroll = r_wr && LF_ON_WRAP && r_col == 6'd63 && r_row == 5'd31;
  always_ff @(posedge clk_pixel) begin
    if (reset) r_state <= CLEAR;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      CLEAR:   w_next = r_addr == 11'd2047 ? IDLE : CLEAR;
      IDLE:    if (w_xfer) w_next = w_print ? PUT : char_data == 8'h0C ? CLEAR :
                                    (char_data == 8'h0A && r_row == 5'd31) ? SCRD : PUT;
      PUT:     w_next = w_wrap_scroll ? SCRD : IDLE;
      SCRD:    w_next = SCWR;
      SCWR:    w_next = r_addr == 11'd1983 ? FILL : SCRD;
      FILL:    w_next = r_addr == 11'd2047 ? IDLE : FILL;
      default: w_next = CLEAR;
    endcase
  end
  // r_addr is zeroed while waiting so CLEAR and the scroll copy both start at address 0
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_addr <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_char <= '0;
      r_wr   <= 1'b0;
    end else begin
      r_addr <= (r_state == IDLE || r_state == PUT) ? '0 : r_state == SCRD ? r_addr : r_addr + 11'd1;
      if (w_xfer) begin
        r_char <= char_data;
        r_wr   <= w_print;
        if (char_data == 8'h0D) r_col <= '0;
        if (char_data == 8'h0A && r_row != 5'd31) r_row <= r_row + 5'd1;
        if (char_data == 8'h08 && r_col != 6'd0) r_col <= r_col - 6'd1;
        if (char_data == 8'h0C) begin
          r_row <= '0;
          r_col <= '0;
        end
      end
      if (r_state == PUT && r_wr) begin
        r_col <= r_col + 6'd1;
        if (LF_ON_WRAP && r_col == 6'd63 && r_row != 5'd31) r_row <= r_row + 5'd1;
      end
    end
  end
  assign ram_addr   = r_state == PUT ? {r_row, r_col} : r_state == SCRD ? r_addr + 11'd64 : r_addr;
  assign ram_wdata  = r_state == PUT ? r_char : r_state == SCWR ? ram_rdata : CLEAR_CHAR;
  assign ram_we     = !reset && (r_state == CLEAR || r_state == FILL || r_state == SCWR || (r_state == PUT && r_wr));
  assign char_ready = r_state == IDLE;
  assign busy       = r_state != IDLE;
  assign cursor_row = r_row;
  assign cursor_col = r_col;
endmodule

// File: tb/tb_text_terminal_writer.sv
// tb_text_terminal_writer: directed character stimulus checked against a
// screen-level model (grid array + queue of expected RAM writes) and literal values.
module tb_text_terminal_writer;
  localparam logic [7:0] CC = 8'h20;
  logic        clk_pixel = 1'b0, reset = 1'b1, char_valid = 1'b0;
  logic [7:0]  char_data = '0, ram_wdata, ram_rdata;
  logic        char_ready, ram_we, busy;
  logic [10:0] ram_addr;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  text_terminal_writer dut (
    .clk_pixel(clk_pixel), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );
  always #5 clk_pixel = ~clk_pixel;
  logic [7:0] mem [2048];
  always @(posedge clk_pixel) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  typedef struct {int a; int d;} wr_t;
  wr_t        q[$];
  logic [7:0] grid [2048];
  int m_row = 0, m_col = 0;
  int n_vec = 0, n_err = 0, cyc = 0, last_wr = 0, prev_wr = 0, n;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic void push(int a, int d);
    wr_t e;
    grid[a] = d[7:0];
    e.a = a;
    e.d = d;
    q.push_back(e);
  endfunction
  function automatic void m_clear();
    for (int i = 0; i < 2048; i++) push(i, CC);
  endfunction
  function automatic void m_lf();
    if (m_row < 31) m_row++;
    else begin
      for (int d = 0; d < 1984; d++) push(d, grid[d + 64]);
      for (int d = 1984; d < 2048; d++) push(d, CC);
    end
  endfunction
  function automatic void m_char(logic [7:0] c);
    if (c >= 8'h20 && c != 8'h7F) begin
      push(m_row * 64 + m_col, c);
      if (m_col == 63) begin
        m_col = 0;
        m_lf();
      end else m_col++;
    end else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h0A) m_lf();
    else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (c == 8'h0C) begin
      m_clear();
      m_row = 0;
      m_col = 0;
    end
  endfunction
  always @(negedge clk_pixel) begin
    #1;
    cyc++;
    if (reset) chk("we_in_reset", ram_we, 0);
    else begin
      if (ram_we) begin
        prev_wr = last_wr;
        last_wr = cyc;
        if (q.size() == 0) chk("unexpected_write", ram_addr, 32'hFFFF_FFFF);
        else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_wdata, e.d);
        end
      end
      if (char_ready) begin
        chk("cursor_row", cursor_row, m_row);
        chk("cursor_col", cursor_col, m_col);
      end
    end
  end
  task automatic send(input logic [7:0] c);
    int t = 0;
    @(negedge clk_pixel);
    char_valid = 1'b1;
    char_data  = c;
    while (!char_ready && t < 10000) begin
      @(negedge clk_pixel);
      t++;
    end
    if (!char_ready) chk("send_timeout", t, 0);
    @(posedge clk_pixel);
    m_char(c);
  endtask
  task automatic sendn(input logic [7:0] c, input int k);
    for (int i = 0; i < k; i++) send(c);
  endtask
  task automatic drop();
    @(negedge clk_pixel);
    char_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (!char_ready && t < 10000) begin
      @(negedge clk_pixel);
      t++;
    end
    chk("idle_reached", char_ready, 1);
  endtask
  task automatic count_busy(output int k);
    k = 0;
    while (busy && k < 20000) begin
      k++;
      @(negedge clk_pixel);
    end
  endtask
  task automatic do_reset();
    @(negedge clk_pixel);
    reset = 1'b1;
    @(negedge clk_pixel);
    q.delete();
    m_row = 0;
    m_col = 0;
    m_clear();
    reset = 1'b0;
  endtask
  task automatic chk_cur(input string nm, input int r, input int c);
    chk({nm, "_row"}, cursor_row, r);
    chk({nm, "_col"}, cursor_col, c);
  endtask
  initial begin
    repeat (3) @(negedge clk_pixel);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_we", ram_we, 0);
    chk_cur("rst", 0, 0);
    m_clear();
    reset = 1'b0;
    count_busy(n);
    chk("init_clear_cycles", n, 2048);
    chk("init_ready", char_ready, 1);
    chk_cur("init", 0, 0);
    chk("init_mem2047", mem[2047], 8'h20);
    send(8'h41);
    send(8'h42);
    drop();
    wait_idle();
    chk("ab_mem0", mem[0], 8'h41);
    chk("ab_mem1", mem[1], 8'h42);
    chk("ab_spacing", last_wr - prev_wr, 2);
    chk_cur("ab", 0, 2);
    send(8'h0D);
    send(8'h0A);
    sendn(8'h55, 64);
    sendn(8'h0A, 3);
    send(8'h01);
    send(8'h7F);
    sendn(8'h78, 64);
    drop();
    wait_idle();
    chk_cur("x64", 6, 0);
    chk("x64_first", mem[320], 8'h78);
    chk("x64_last", mem[383], 8'h78);
    send(8'h08);
    drop();
    wait_idle();
    chk_cur("bs_col0", 6, 0);
    sendn(8'h0A, 25);
    sendn(8'h20, 10);
    drop();
    wait_idle();
    chk_cur("pre_scroll", 31, 10);
    send(8'h0A);
    drop();
    count_busy(n);
    chk("scroll_cycles", n, 4032);
    chk_cur("scroll", 31, 10);
    chk("scroll_row0_a", mem[0], 8'h55);
    chk("scroll_row0_b", mem[63], 8'h55);
    chk("scroll_x_row4", mem[256], 8'h78);
    chk("scroll_fill_a", mem[1984], 8'h20);
    chk("scroll_fill_b", mem[2047], 8'h20);
    sendn(8'h7A, 54);
    drop();
    count_busy(n);
    chk("wrap_scroll_cycles", n, 4033);
    chk_cur("wrap", 31, 0);
    chk("wrap_row30", mem[1930], 8'h7A);
    chk("wrap_row31", mem[2047], 8'h20);
    send(8'h80);
    send(8'h0A);
    drop();
    repeat (1000) @(negedge clk_pixel);
    do_reset();
    count_busy(n);
    chk("midscroll_reset_clear", n, 2048);
    chk_cur("midscroll_reset", 0, 0);
    chk("midscroll_mem0", mem[0], 8'h20);
    sendn(8'h0A, 12);
    sendn(8'h20, 40);
    drop();
    wait_idle();
    chk_cur("pre_cr", 12, 40);
    send(8'h0D);
    drop();
    wait_idle();
    chk_cur("cr", 12, 0);
    send(8'h0C);
    drop();
    count_busy(n);
    chk("ff_clear_cycles", n, 2048);
    chk_cur("ff", 0, 0);
    send(8'h08);
    drop();
    wait_idle();
    chk_cur("bs_home", 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/text_terminal_writer.md
TEXT_TERMINAL_WRITER -- requirements
Module: text_terminal_writer

Interface
REQ-001 The block SHALL have parameter CLEAR_CHAR, default 8'h20, meaning the byte written by clear and scroll-fill operations.
REQ-002 The block SHALL have parameter LF_ON_WRAP, default 1, meaning a column wrap also advances the row (0 = wrap to column 0 of the same row).
REQ-003 The block SHALL have port clk_pixel, input, 1 bit: the single clock, the same pixel clock that drives the text display.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port char_valid, input, 1 bit: the upstream character is valid.
REQ-006 The block SHALL have port char_data, input, 8 bits: the ASCII/control byte.
REQ-007 The block SHALL have port char_ready, output, 1 bit: the block accepts char_data in this cycle.
REQ-008 The block SHALL have port ram_addr, output, 11 bits: the display RAM address {row[4:0], col[5:0]} for a 64x32 text grid.
REQ-009 The block SHALL have port ram_wdata, output, 8 bits: the display RAM write data.
REQ-010 The block SHALL have port ram_we, output, 1 bit: the display RAM write strobe.
REQ-011 The block SHALL have port ram_rdata, input, 8 bits: the display RAM read data, valid exactly one cycle after ram_addr is presented with ram_we=0.
REQ-012 The block SHALL have port cursor_row, output, 5 bits: the current cursor row.
REQ-013 The block SHALL have port cursor_col, output, 6 bits: the current cursor column.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The block SHALL implement the states CLEAR, IDLE, PUT, SCRD, SCWR and FILL.
REQ-016 A transfer SHALL occur only on a cycle with char_valid=1 and char_ready=1, and char_ready SHALL be 1 only in IDLE.
REQ-017 After a transfer the block SHALL leave IDLE, so the maximum throughput is one character per two cycles.
REQ-018 For a byte of 8'h20..8'h7E or 8'h80..8'hFF, the block SHALL enter PUT and assert ram_we=1 for one cycle, with ram_addr={row,col} and ram_wdata=char_data.
REQ-019 In that same PUT cycle the block SHALL advance the cursor: col+1; at col=63, col becomes 0 and, if LF_ON_WRAP=1, a line feed is applied.
REQ-020 For 8'h0D (CR), the block SHALL set col=0, perform no RAM access and spend one cycle out of IDLE.
REQ-021 For 8'h0A (LF), the block SHALL set row+1 when row<31; when row=31 it SHALL start a scroll and leave row at 31.
REQ-022 For 8'h08 (BS), the block SHALL set col-1 when col>0 and otherwise leave the cursor unchanged, with no RAM write.
REQ-023 For 8'h0C (FF), the block SHALL enter CLEAR and then home the cursor to (0,0).
REQ-024 All other control bytes (8'h00..8'h1F not listed, and 8'h7F) SHALL be accepted and discarded in one cycle.
REQ-025 A scroll SHALL alternate SCRD and SCWR for dst=0..1983.
REQ-026 In SCRD the block SHALL drive ram_addr=dst+64 with ram_we=0.
REQ-027 In SCWR the block SHALL drive ram_addr=dst, ram_we=1 and ram_wdata=ram_rdata.
REQ-028 After the copy the block SHALL enter FILL, writing CLEAR_CHAR to addresses 1984..2047, one per cycle, and then return to IDLE.
REQ-029 A scroll SHALL take exactly 2*1984+64 = 4032 cycles.
REQ-030 CLEAR SHALL write CLEAR_CHAR to addresses 0..2047 in ascending order, one per cycle (2048 cycles), and then return to IDLE.
REQ-031 A wrap at (row 31, col 63) with LF_ON_WRAP=1 SHALL perform the PUT write first and then the scroll, ending with the cursor at (31,0).
REQ-032 The block SHALL hold ram_we=0 in IDLE and on all SCRD cycles.
REQ-033 The block SHALL never drive ram_addr outside 0..2047; address counters SHALL be 11 bits with no wrap during CLEAR, SCRD/SCWR or FILL.
REQ-034 Input values on char_data SHALL be ignored when the block is not in IDLE.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL enter CLEAR at address 0, from any state including mid-scroll or mid-fill.
REQ-036 The reset values SHALL be: char_ready=0, busy=1, ram_we=0, cursor_row=0 and cursor_col=0.
REQ-037 The first cycle after reset deasserts SHALL write CLEAR_CHAR to address 0.
REQ-038 IDLE SHALL be reached 2048 cycles after reset deasserts.

Verification
REQ-039 Reset, then wait: the bench SHALL see 2048 writes of 8'h20 to addresses 0..2047, then char_ready=1 with cursor (0,0).
REQ-040 Send "A","B" back-to-back with char_valid held high: the bench SHALL see writes 8'h41@0 and 8'h42@1, two cycles apart, ending with cursor (0,2).
REQ-041 Send 64 x "x" from (5,0): the bench SHALL see writes to 320..383 and a final cursor of (6,0); then sending BS at col 0 SHALL leave the cursor at (6,0).
REQ-042 Preload row 1 with 8'h55 and put the cursor at (31,10), then send LF: the bench SHALL see row 0 = 8'h55, addresses 1984..2047 = 8'h20, busy for 4032 cycles and cursor (31,10).
REQ-043 Assert reset for one cycle midway through a scroll: the bench SHALL see the copy abort and a full 2048-cycle clear restart at address 0 with cursor (0,0).
REQ-044 Send CR, then FF from (12,40): the bench SHALL see the cursor at (12,0) after CR, then a 2048-cycle clear and cursor (0,0).
